// File: rtl/switch_debouncer_if.sv
// -----------------------------------------------------------------------------
// switch_debouncer_if
// Bundles the switch-side signals of switch_debouncer.
//   sw_in   : raw asynchronous switch levels (bit0 -> SW0, bit1 -> SW1)
//   sw_db   : debounced, synchronised switch levels
//   sw_rise : one-cycle pulse when sw_db[i] goes 0->1
//   sw_fall : one-cycle pulse when sw_db[i] goes 1->0
// master : the side that drives the raw switches and consumes clean levels
// slave  : the debouncer itself
// -----------------------------------------------------------------------------
interface switch_debouncer_if #(
  parameter int N_SW = 2
);
  logic [N_SW-1:0] sw_in;
  logic [N_SW-1:0] sw_db;
  logic [N_SW-1:0] sw_rise;
  logic [N_SW-1:0] sw_fall;

  modport master (
    output sw_in,
    input  sw_db,
    input  sw_rise,
    input  sw_fall
  );

  modport slave (
    input  sw_in,
    output sw_db,
    output sw_rise,
    output sw_fall
  );
endinterface

// File: rtl/switch_debouncer.sv
// -----------------------------------------------------------------------------
// switch_debouncer
// Input conditioning for the colour-select FSM: each raw switch is brought into
// the clk domain through a two-flop synchroniser, then debounced by its own
// four-state FSM and counter. A new level is accepted only after the
// synchronised input has disagreed with the current level for
// DEBOUNCE_CYCLES+1 consecutive samples (entry sample plus DEBOUNCE_CYCLES
// counted samples).
//
// Ports
//   clk   : system clock, all logic on posedge
//   reset : synchronous active-low reset
//   bus   : switch_debouncer_if.slave (sw_in in; sw_db, sw_rise, sw_fall out)
//
// Configuration macro
//   SW_EDGE_PULSE_EN : when defined, sw_rise/sw_fall carry one-cycle edge
//                      pulses coincident with the new sw_db level. When
//                      undefined the pulse flops are not built and both
//                      outputs are tied to zero; sw_db is unaffected.
// -----------------------------------------------------------------------------
module switch_debouncer #(
  parameter int N_SW            = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic               clk,
  input  logic               reset,
  switch_debouncer_if.slave  bus
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_WAIT_HIGH = 2'd1,
    ST_HIGH      = 2'd2,
    ST_WAIT_LOW  = 2'd3
  } state_e;

  logic [N_SW-1:0]  sync1_q, sync1_d;
  logic [N_SW-1:0]  sync2_q, sync2_d;
  logic [N_SW-1:0]  db_q, db_d;
  state_e           state_q [N_SW];
  state_e           state_d [N_SW];
  logic [CNT_W-1:0] cnt_q   [N_SW];
  logic [CNT_W-1:0] cnt_d   [N_SW];

  // Next-state logic: synchroniser shift plus one debounce FSM per switch.
  always_comb begin
    sync1_d = bus.sw_in;
    sync2_d = sync1_q;
    db_d    = db_q;
    for (int i = 0; i < N_SW; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_LOW: begin
          if (sync2_q[i]) begin
            state_d[i] = ST_WAIT_HIGH;
            cnt_d[i]   = '0;
          end
        end
        ST_WAIT_HIGH: begin
          if (!sync2_q[i]) begin
            state_d[i] = ST_LOW;        // bounce rejected
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = ST_HIGH;
            cnt_d[i]   = '0;
            db_d[i]    = 1'b1;
          end else begin
            cnt_d[i]   = cnt_q[i] + 1'b1;
          end
        end
        ST_HIGH: begin
          if (!sync2_q[i]) begin
            state_d[i] = ST_WAIT_LOW;
            cnt_d[i]   = '0;
          end
        end
        ST_WAIT_LOW: begin
          if (sync2_q[i]) begin
            state_d[i] = ST_HIGH;       // bounce rejected
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = ST_LOW;
            cnt_d[i]   = '0;
            db_d[i]    = 1'b0;
          end else begin
            cnt_d[i]   = cnt_q[i] + 1'b1;
          end
        end
        default: begin
          state_d[i] = ST_LOW;
          cnt_d[i]   = '0;
          db_d[i]    = 1'b0;
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      for (int i = 0; i < N_SW; i++) begin
        state_q[i] <= ST_LOW;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      for (int i = 0; i < N_SW; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign bus.sw_db = db_q;

`ifdef SW_EDGE_PULSE_EN
  logic [N_SW-1:0] rise_q, rise_d;
  logic [N_SW-1:0] fall_q, fall_d;

  // Pulses are derived from the level change being committed this edge, so
  // they land in the same cycle as the new sw_db and last exactly one cycle.
  always_comb begin
    rise_d = db_d & ~db_q;
    fall_d = ~db_d & db_q;
  end

  // Pulse registers; reset clears them so a reset never emits a pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign bus.sw_rise = rise_q;
  assign bus.sw_fall = fall_q;
`else
  assign bus.sw_rise = '0;
  assign bus.sw_fall = '0;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// -----------------------------------------------------------------------------
// tb_switch_debouncer
// Directed scenarios (clean press, bounce, release, simultaneous press, reset
// mid-wait) followed by randomized switch activity. The reference model works
// on run lengths: a bit's clean level flips once the two-cycle-delayed input
// has disagreed with it for DEBOUNCE_CYCLES+1 consecutive edges.
// -----------------------------------------------------------------------------
module tb_switch_debouncer;
  localparam int N_SW = 2;
  localparam int DB   = 4;
`ifdef SW_EDGE_PULSE_EN
  localparam logic [1:0] PM = 2'b11;
`else
  localparam logic [1:0] PM = 2'b00;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  switch_debouncer_if #(.N_SW(N_SW)) bus ();

  switch_debouncer #(.N_SW(N_SW), .DEBOUNCE_CYCLES(DB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [1:0] hist [$];           // sampled sw_in values, newest at back
  logic [1:0] m_db;
  logic [1:0] m_rise;
  logic [1:0] m_fall;
  int         m_run [N_SW];

  task automatic check_val(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    hist = {2'b00, 2'b00};
    m_db = 2'b00; m_rise = 2'b00; m_fall = 2'b00;
    for (int i = 0; i < N_SW; i++) m_run[i] = 0;
  endtask

  // One clock edge of the model: the value the debouncer sees is the one
  // sampled two edges earlier.
  task automatic model_edge(input logic [1:0] in, input logic rst);
    logic [1:0] seen;
    if (!rst) begin
      model_reset();
    end else begin
      seen   = hist[0];
      m_rise = 2'b00;
      m_fall = 2'b00;
      for (int i = 0; i < N_SW; i++) begin
        if (seen[i] != m_db[i]) begin
          m_run[i]++;
          if (m_run[i] == DB + 1) begin
            if (seen[i]) m_rise[i] = 1'b1;
            else         m_fall[i] = 1'b1;
            m_db[i]  = seen[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      void'(hist.pop_front());
      hist.push_back(in);
    end
  endtask

  task automatic step(input logic [1:0] in, input logic rst);
    bus.sw_in = in;
    reset     = rst;
    @(posedge clk);
    model_edge(in, rst);
    #1;
    check_val("sw_db",   bus.sw_db,   m_db);
    check_val("sw_rise", bus.sw_rise, m_rise & PM);
    check_val("sw_fall", bus.sw_fall, m_fall & PM);
    @(negedge clk);
  endtask

  initial begin
    logic [1:0] v;
    int         hold;
    model_reset();
    bus.sw_in = 2'b00;
    reset     = 1'b0;
    @(negedge clk);
    repeat (3) step(2'b00, 1'b0);
    check_val("reset_db",   bus.sw_db,   2'b00);
    check_val("reset_rise", bus.sw_rise, 2'b00);
    repeat (2) step(2'b00, 1'b1);

    // Clean press on SW0: accepted at edge E+6
    for (int k = 0; k <= 6; k++) begin
      step(2'b01, 1'b1);
      if (k == 5) check_val("s1_pre_db", bus.sw_db, 2'b00);
    end
    check_val("s1_db",   bus.sw_db,   2'b01);
    check_val("s1_rise", bus.sw_rise, PM & 2'b01);
    step(2'b01, 1'b1);
    check_val("s1_rise_once", bus.sw_rise, 2'b00);
    repeat (2) step(2'b01, 1'b1);

    // Release
    for (int k = 0; k <= 6; k++) begin
      step(2'b00, 1'b1);
      if (k == 5) check_val("s3_pre_db", bus.sw_db, 2'b01);
    end
    check_val("s3_db",   bus.sw_db,   2'b00);
    check_val("s3_fall", bus.sw_fall, PM & 2'b01);
    step(2'b00, 1'b1);
    check_val("s3_fall_once", bus.sw_fall, 2'b00);

    // Bounces of 3 and DEBOUNCE_CYCLES cycles are both rejected
    repeat (3) step(2'b01, 1'b1);
    repeat (8) step(2'b00, 1'b1);
    check_val("s2_db3", bus.sw_db, 2'b00);
    repeat (DB) step(2'b01, 1'b1);
    repeat (8) step(2'b00, 1'b1);
    check_val("s2_db4", bus.sw_db, 2'b00);

    // Simultaneous press
    for (int k = 0; k <= 6; k++) step(2'b11, 1'b1);
    check_val("s4_db",   bus.sw_db,   2'b11);
    check_val("s4_rise", bus.sw_rise, PM & 2'b11);
    repeat (8) step(2'b00, 1'b1);
    check_val("s4_back", bus.sw_db, 2'b00);

    // Reset mid-wait
    for (int k = 0; k <= 11; k++) begin
      step(2'b10, (k != 4));
      if (k == 5)  check_val("s5_after_rst", bus.sw_db, 2'b00);
      if (k == 10) check_val("s5_pre_db",    bus.sw_db, 2'b00);
    end
    check_val("s5_db",   bus.sw_db,   2'b10);
    check_val("s5_rise", bus.sw_rise, PM & 2'b10);
    repeat (8) step(2'b00, 1'b1);

    // Randomized activity: hold lengths straddle the acceptance threshold
    for (int n = 0; n < 120; n++) begin
      v    = 2'($urandom);
      hold = $urandom_range(1, 9);
      for (int h = 0; h < hold; h++) begin
        if ($urandom_range(0, 7) == 0) v[$urandom_range(0, 1)] ^= 1'b1;
        step(v, ($urandom_range(0, 63) != 0));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
